score_keeper: RTL and testbench

- Upstream producer of the 32-bit binary `score` consumed by the on-screen score renderer.
- Accepts duck-hit events from the game logic and buffers them in a small FIFO.
- Converts each hit to points, using a per-round multiplier and a perfect-round bonus, and accumulates a saturating total.
- Drives a displayed score that tallies up toward the total once per video frame, for the count-up effect.

---
 rtl/score_keeper.sv | 185 ++++++++++++++++++
 tb/tb_score_keeper.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// Score keeper: buffers duck-hit events, converts them to points with a round
// multiplier and perfect-round bonus, and tallies a displayed score per frame.
module score_keeper #(
    parameter int unsigned PTS_TYPE0       = 500,
    parameter int unsigned PTS_TYPE1       = 1000,
    parameter int unsigned PTS_TYPE2       = 1500,
    parameter int unsigned MAX_MULT        = 4,
    parameter int unsigned DUCKS_PER_ROUND = 10,
    parameter int unsigned PERFECT_BONUS   = 10000,
    parameter int unsigned MAX_SCORE       = 999999999,
    parameter int unsigned TALLY_STEP      = 100,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_clk,
    input  logic        game_reset,
    input  logic        hit,
    input  logic [1:0]  duck_type,
    input  logic        round_end,
    output logic [31:0] score,
    output logic [31:0] score_total,
    output logic [7:0]  round_num,
    output logic [3:0]  hits_in_round,
    output logic        perfect,
    output logic        fifo_overflow,
    output logic        busy
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        ADD,
        BONUS,
        ROUND_ADV
    } state_t;

    state_t             state;
    logic [1:0]         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               pending;
    logic               frame_d;
    logic               frame_edge;
    logic [31:0]        pts_reg;
    logic [31:0]        base_pts;
    logic [31:0]        mult;
    logic [31:0]        pts_calc;
    logic [32:0]        add_sum;
    logic [32:0]        bonus_sum;
    logic [32:0]        tally_sum;
    logic [31:0]        add_sat;
    logic [31:0]        bonus_sat;
    logic [31:0]        tally_next;

    assign full       = (count == CNT_W'(FIFO_DEPTH));
    assign empty      = (count == '0);
    assign push       = hit && !full && !game_reset;
    assign pop        = (state == POP);
    assign frame_edge = frame_clk && !frame_d;
    assign busy       = (state != IDLE) || !empty;

    // Points for the entry at the FIFO head, scaled by the capped round multiplier
    always_comb begin
        base_pts = 32'(PTS_TYPE2);
        case (fifo_mem[rd_ptr])
            2'd0:    base_pts = 32'(PTS_TYPE0);
            2'd1:    base_pts = 32'(PTS_TYPE1);
            default: base_pts = 32'(PTS_TYPE2);
        endcase
        mult     = (32'(round_num) >= MAX_MULT) ? 32'(MAX_MULT) : 32'(round_num);
        pts_calc = base_pts * mult;
    end

    // Saturating sums use a 33-bit intermediate so the compare sees any carry
    always_comb begin
        add_sum    = {1'b0, score_total} + {1'b0, pts_reg};
        bonus_sum  = {1'b0, score_total} + 33'(PERFECT_BONUS);
        tally_sum  = {1'b0, score} + 33'(TALLY_STEP);
        add_sat    = (add_sum > 33'(MAX_SCORE)) ? 32'(MAX_SCORE) : add_sum[31:0];
        bonus_sat  = (bonus_sum > 33'(MAX_SCORE)) ? 32'(MAX_SCORE) : bonus_sum[31:0];
        tally_next = (tally_sum > {1'b0, score_total}) ? score_total : tally_sum[31:0];
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= duck_type;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state         <= IDLE;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            pending       <= 1'b0;
            frame_d       <= 1'b0;
            pts_reg       <= '0;
            score         <= '0;
            score_total   <= '0;
            round_num     <= 8'd1;
            hits_in_round <= '0;
            perfect       <= 1'b0;
            fifo_overflow <= 1'b0;
        end else begin
            frame_d <= frame_clk;
            if (game_reset) begin
                state         <= IDLE;
                rd_ptr        <= '0;
                wr_ptr        <= '0;
                count         <= '0;
                pending       <= 1'b0;
                pts_reg       <= '0;
                score         <= '0;
                score_total   <= '0;
                round_num     <= 8'd1;
                hits_in_round <= '0;
                perfect       <= 1'b0;
                fifo_overflow <= 1'b0;
            end else begin
                perfect <= 1'b0;

                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
                if (hit && full) fifo_overflow <= 1'b1;

                // Count-up display chases the total it saw before this edge
                if (frame_edge && (score < score_total)) score <= tally_next;

                if (round_end) begin
                    pending <= 1'b1;
                end else if (state == BONUS) begin
                    pending <= 1'b0;
                end

                case (state)
                    IDLE: begin
                        if (!empty) begin
                            state <= POP;
                        end else if (pending) begin
                            state <= BONUS;
                        end
                    end
                    POP: begin
                        pts_reg <= pts_calc;
                        if (hits_in_round != 4'hF) hits_in_round <= hits_in_round + 4'd1;
                        state <= ADD;
                    end
                    ADD: begin
                        score_total <= add_sat;
                        state       <= IDLE;
                    end
                    BONUS: begin
                        if (32'(hits_in_round) >= DUCKS_PER_ROUND) begin
                            score_total <= bonus_sat;
                            perfect     <= 1'b1;
                        end
                        state <= ROUND_ADV;
                    end
                    ROUND_ADV: begin
                        if (round_num != 8'hFF) round_num <= round_num + 8'd1;
                        hits_in_round <= '0;
                        state         <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: per-cycle comparison against a queue-based scoring
// model, plus hand-computed expectations and a saturation-override instance.
module tb_score_keeper;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b1;
    logic        frame_clk, game_reset, hit, round_end;
    logic [1:0]  duck_type;
    logic [31:0] score, score_total;
    logic [7:0]  round_num;
    logic [3:0]  hits_in_round;
    logic        perfect, fifo_overflow, busy;

    logic        frame_b, game_reset_b, hit_b, round_end_b;
    logic [1:0]  duck_type_b;
    logic [31:0] score_b, score_total_b;
    logic [7:0]  round_num_b;
    logic [3:0]  hits_b;
    logic        perfect_b, overflow_b, busy_b;

    int cyc_chk = 0, cyc_err = 0, lit_chk = 0, lit_err = 0, perf_cnt = 0;

    always #10 Clk = ~Clk;

    score_keeper dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .game_reset(game_reset),
        .hit(hit), .duck_type(duck_type), .round_end(round_end),
        .score(score), .score_total(score_total), .round_num(round_num),
        .hits_in_round(hits_in_round), .perfect(perfect), .fifo_overflow(fifo_overflow),
        .busy(busy)
    );

    score_keeper #(.MAX_SCORE(2000)) dut_b (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_b), .game_reset(game_reset_b),
        .hit(hit_b), .duck_type(duck_type_b), .round_end(round_end_b),
        .score(score_b), .score_total(score_total_b), .round_num(round_num_b),
        .hits_in_round(hits_b), .perfect(perfect_b), .fifo_overflow(overflow_b),
        .busy(busy_b)
    );

    // ---------------- reference model ----------------
    // phase: 0 waiting, 1 taking a hit, 2 crediting it, 3 closing round, 4 next round
    int     m_q[$];
    int     m_phase = 0, m_round = 1, m_hits = 0, m_accepted = 0, m_sz0;
    longint m_total = 0, m_score = 0, m_pts = 0;
    bit     m_pending = 0, m_ovf = 0, m_perfect = 0, m_frame_d = 0, m_fe;

    function automatic longint base_of(int t);
        if (t == 0) return 500;
        if (t == 1) return 1000;
        return 1500;
    endfunction

    function automatic longint lmin(longint a, longint b);
        return (a < b) ? a : b;
    endfunction

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n || game_reset) begin
            if (!Reset_n) m_frame_d = 0;
            else m_frame_d = frame_clk;
            m_q.delete();
            m_phase = 0; m_round = 1; m_hits = 0; m_accepted = 0;
            m_total = 0; m_score = 0; m_pts = 0;
            m_pending = 0; m_ovf = 0; m_perfect = 0;
        end else begin
            m_fe = frame_clk && !m_frame_d;
            m_frame_d = frame_clk;
            if (m_fe && m_score < m_total) m_score = lmin(m_score + 100, m_total);
            m_perfect = 0;
            m_sz0 = m_q.size();
            case (m_phase)
                0: if (m_sz0 > 0) m_phase = 1; else if (m_pending) m_phase = 3;
                1: begin
                    m_pts = base_of(m_q.pop_front()) * lmin(m_round, 4);
                    m_hits = int'(lmin(m_hits + 1, 15));
                    m_phase = 2;
                end
                2: begin m_total = lmin(m_total + m_pts, 999999999); m_phase = 0; end
                3: begin
                    if (m_hits >= 10) begin
                        m_total = lmin(m_total + 10000, 999999999);
                        m_perfect = 1;
                    end
                    m_pending = 0;
                    m_phase = 4;
                end
                default: begin m_round = int'(lmin(m_round + 1, 255)); m_hits = 0; m_phase = 0; end
            endcase
            if (hit) begin
                if (m_sz0 < 4) begin m_q.push_back(int'(duck_type)); m_accepted++; end
                else m_ovf = 1;
            end
            if (round_end) m_pending = 1;
        end
    end

    // Per-cycle compare, sampled on the falling edge
    always @(negedge Clk) begin
        if (Reset_n) begin
            cyc_chk++;
            if (perfect) perf_cnt++;
            if (longint'(score) != m_score || longint'(score_total) != m_total ||
                int'(round_num) != m_round || int'(hits_in_round) != m_hits ||
                perfect != m_perfect || fifo_overflow != m_ovf ||
                busy != (m_phase != 0 || m_q.size() != 0)) begin
                cyc_err++;
                $display("FAIL cycle t=%0t score=%0d/%0d total=%0d/%0d round=%0d/%0d hits=%0d/%0d perf=%0d/%0d ovf=%0d/%0d busy=%0d/%0d",
                         $time, score, m_score, score_total, m_total, round_num, m_round,
                         hits_in_round, m_hits, perfect, m_perfect, fifo_overflow, m_ovf,
                         busy, (m_phase != 0 || m_q.size() != 0));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic check(input string name, input longint act, input longint exp);
        lit_chk++;
        if (act != exp) begin
            lit_err++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic do_hit(input logic [1:0] t);
        hit = 1'b1; duck_type = t; tick(1); hit = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin tick(1); n++; end
        lit_chk++;
        if (busy) begin lit_err++; $display("FAIL wait_idle actual=busy required=idle"); end
    endtask

    task automatic end_round();
        round_end = 1'b1; tick(1); round_end = 1'b0; tick(1); wait_idle();
    endtask

    task automatic frame_pulse();
        frame_clk = 1'b1; tick(1); frame_clk = 1'b0; tick(1);
    endtask

    int perf0;

    initial begin
        frame_clk = 0; game_reset = 0; hit = 0; round_end = 0; duck_type = 0;
        frame_b = 0; game_reset_b = 0; hit_b = 0; round_end_b = 0; duck_type_b = 0;
        #2 Reset_n = 1'b0;
        repeat (3) @(posedge Clk);
        #1 Reset_n = 1'b1;
        check("rst_score", score, 0);
        check("rst_total", score_total, 0);
        check("rst_round", round_num, 1);
        check("rst_hits", hits_in_round, 0);
        check("rst_ovf", fifo_overflow, 0);

        // Reset asserted while the first hit is in its add step
        do_hit(0); tick(2);
        Reset_n = 1'b0; #2;
        check("midadd_total", score_total, 0);
        check("midadd_round", round_num, 1);
        check("midadd_busy", busy, 0);
        tick(1); Reset_n = 1'b1;

        // Hit latency: points appear after the third edge
        do_hit(0);
        check("lat_e0", score_total, 0);
        tick(2);
        check("lat_e2", score_total, 0);
        tick(1);
        check("lat_e3", score_total, 500);

        for (int i = 1; i <= 5; i++) begin
            frame_pulse();
            check("tally_step", score, 100 * i);
        end
        frame_pulse();
        check("tally_hold", score, 500);

        // Multiplier: round 3 and capped at round 6
        perf0 = perf_cnt;
        end_round(); end_round();
        check("round3", round_num, 3);
        do_hit(2); wait_idle();
        check("mult3_total", score_total, 5000);
        end_round(); end_round(); end_round();
        check("round6", round_num, 6);
        do_hit(2); wait_idle();
        check("mult_cap_total", score_total, 11000);
        check("no_perfect", perf_cnt - perf0, 0);

        // Perfect round
        game_reset = 1'b1; tick(1); game_reset = 1'b0;
        check("gr_total", score_total, 0);
        check("gr_round", round_num, 1);
        perf0 = perf_cnt;
        for (int i = 0; i < 10; i++) begin do_hit(0); tick(3); end
        check("perf_hits", hits_in_round, 10);
        check("perf_pre_total", score_total, 5000);
        end_round();
        check("perf_total", score_total, 15000);
        check("perf_pulses", perf_cnt - perf0, 1);
        check("perf_round", round_num, 2);
        check("perf_hits_clr", hits_in_round, 0);

        // game_reset wins over hit and round_end in the same cycle
        game_reset = 1'b1; hit = 1'b1; round_end = 1'b1; tick(1);
        game_reset = 1'b0; hit = 1'b0; round_end = 1'b0;
        tick(4);
        check("prio_busy", busy, 0);
        check("prio_round", round_num, 1);
        check("prio_total", score_total, 0);

        // Six consecutive hits overrun the four-entry buffer
        hit = 1'b1; duck_type = 2'd0; tick(6); hit = 1'b0;
        wait_idle();
        check("ovf_flag", fifo_overflow, 1);
        check("ovf_hits_vs_pushes", hits_in_round, m_accepted);
        check("ovf_hits", hits_in_round, 5);
        check("ovf_total", score_total, 2500);

        // Saturation with a 2000 ceiling, then game_reset during a tally
        for (int i = 1; i <= 5; i++) begin
            hit_b = 1'b1; duck_type_b = 2'd0; tick(1); hit_b = 1'b0; tick(3);
            check("sat_total", score_total_b, (i < 4) ? 500 * i : 2000);
        end
        frame_b = 1'b1; tick(1); frame_b = 1'b0; tick(1);
        check("sat_tally", score_b, 100);
        frame_b = 1'b1; game_reset_b = 1'b1; tick(1);
        frame_b = 1'b0; game_reset_b = 1'b0;
        check("grtally_score", score_b, 0);
        check("grtally_total", score_total_b, 0);

        tick(2);
        $display("CHECKS %0d ERRORS %0d", cyc_chk + lit_chk, cyc_err + lit_err);
        $finish;
    end

endmodule
